// File: rtl/comb_arbiter_if.sv
// comb_arbiter_if: request and response channels between the requesting
// agents and comb_arbiter.
//   req_valid[i]          requester i has an operand set to offer
//   req_abcd[4i+3:4i]     operands of requester i, {a,b,c,d}, a at the MSB
//   req_ready[i]          one-hot accept back to requester i
//   rsp_valid/rsp_id/rsp_y  response channel, rsp_ready is the consumer side
// slave modport: the arbiter. master modport: the requesters/consumer.
interface comb_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_abcd;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_y;
  logic              rsp_ready;

  modport slave (
    input  req_valid, req_abcd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport master (
    output req_valid, req_abcd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/comb_arbiter.sv
// comb_arbiter: round-robin scheduler sharing one combinational `comb` unit
// between NREQ requesters. One operand set is accepted at a time, driven onto
// comb_a..comb_d for SETTLE cycles, then comb_y is sampled and returned on the
// response channel tagged with the requester index.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       request/response channels, see comb_arbiter_if
//   comb_a..comb_d    registered operands to the comb unit
//   comb_y            comb unit output
//   busy              high whenever the FSM is not idle
//   dbg_state         current FSM state (0 idle, 1 settle, 2 resp)
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high. A response holds rsp_valid, rsp_id and rsp_y
// stable until that edge. Requesters may drop req_valid without a transfer;
// an ungranted request is simply forgotten.
module comb_arbiter #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  comb_arbiter_if.slave    bus,
  output logic             comb_a,
  output logic             comb_b,
  output logic             comb_c,
  output logic             comb_d,
  input  logic             comb_y,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [3:0]      cnt;
  logic [IDW-1:0]  id_q;
  logic            rsp_valid_q;
  logic            rsp_y_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  logic            found;
  logic [3:0]      sel_abcd;
  logic [IDW-1:0]  next_ptr;

  // base + k reduced modulo NREQ; k < NREQ so one subtraction is enough and
  // a non-power-of-two NREQ never yields an out-of-range index.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Search from ptr upward for the first valid requester. Only idle offers
  // a grant, so req_ready is all-zero while a transaction is in flight.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    if (state == S_IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = wrap_idx(ptr, k);
        if (!found && bus.req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  assign sel_abcd = bus.req_abcd[{grant_id, 2'b00} +: 4];
  assign next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign busy          = (state != S_IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 1'b0;
      comb_a      <= 1'b0;
      comb_b      <= 1'b0;
      comb_c      <= 1'b0;
      comb_d      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            {comb_a, comb_b, comb_c, comb_d} <= sel_abcd;
            id_q  <= grant_id;
            cnt   <= 4'(SETTLE - 1);
            ptr   <= next_ptr;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Operands have been stable for SETTLE full cycles when cnt hits 0.
          if (cnt == 4'd0) begin
            rsp_y_q     <= comb_y;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // No new accept in the handshake cycle: idle is entered first.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
